wb_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single 8-bit-data, 16-bit-address Wishbone slave bus among N masters.
- Masters: the RBCP-to-Wishbone bridge plus future autonomous masters (sensor pollers, boot-time config sequencers).
- Sits between the masters and the slave decode that feeds reg_table, I2C, SPI and UART cores.
- Adds a per-transfer ack watchdog that converts a hung slave into an error on the owning master.

---
 rtl/wb_rr_arbiter_pkg.sv | 24 ++
 rtl/wb_rr_arbiter_if.sv | 42 ++++
 rtl/wb_rr_arbiter_tmo_cnt.sv | 40 ++++
 rtl/wb_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_rr_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared Wishbone definitions for the round-robin arbiter slice: bus widths,
// arbiter state encoding and a one-hot to index helper.
package wb_pkg;

  localparam int ADR_W_DEF = 16;
  localparam int DATA_W    = 8;
  localparam int MAX_MST   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // Index of the set bit in a one-hot vector (0 when no bit is set).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_MST-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MST; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of the per-master Wishbone request side and the shared slave side.
// The "slave" modport is the arbiter's view (it is the slave of every
// master); the "master" modport is the surrounding masters plus slave decode.
interface wb_rr_arbiter_if
  import wb_pkg::*;
#(
  parameter int N_MST = 2,
  parameter int ADR_W = ADR_W_DEF
) ();

  logic [N_MST-1:0]        M_CYC;
  logic [N_MST-1:0]        M_STB;
  logic [N_MST-1:0]        M_WE;
  logic [N_MST*ADR_W-1:0]  M_ADR;
  logic [N_MST*DATA_W-1:0] M_WDAT;
  logic [DATA_W-1:0]       M_RDAT;
  logic [N_MST-1:0]        M_ACK;
  logic [N_MST-1:0]        M_ERR;
  logic [N_MST-1:0]        GNT;
  logic                    S_CYC;
  logic                    S_STB;
  logic                    S_WE;
  logic [ADR_W-1:0]        S_ADR;
  logic [DATA_W-1:0]       S_WDAT;
  logic [DATA_W-1:0]       S_RDAT;
  logic                    S_ACK;
  logic                    S_ERR;
  logic                    TMO_SEEN;   // sticky watchdog debug probe

  modport slave (
    input  M_CYC, M_STB, M_WE, M_ADR, M_WDAT, S_RDAT, S_ACK, S_ERR,
    output M_RDAT, M_ACK, M_ERR, GNT, S_CYC, S_STB, S_WE, S_ADR, S_WDAT,
           TMO_SEEN
  );

  modport master (
    output M_CYC, M_STB, M_WE, M_ADR, M_WDAT, S_RDAT, S_ACK, S_ERR,
    input  M_RDAT, M_ACK, M_ERR, GNT, S_CYC, S_STB, S_WE, S_ADR, S_WDAT,
           TMO_SEEN
  );

endinterface

// File: rtl/wb_rr_arbiter_tmo_cnt.sv
// Per-transfer ack watchdog: counts owned strobe cycles that go unanswered
// and raises a one-cycle tmo_hit after TMO_CYC of them.
module wb_tmo_cnt #(
  parameter int TMO_CYC = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic own,
  input  logic stb,
  input  logic ack,
  input  logic err,
  output logic tmo_hit,
  output logic tmo_seen
);

  localparam logic [15:0] LAST = 16'(TMO_CYC - 1);

  logic [15:0] cnt;
  logic        wait_cyc;
  logic        expire;

  // A wait cycle is an owned strobe with no answer; the hit cycle itself
  // never counts so the count restarts cleanly after a timeout.
  assign wait_cyc = own & stb & ~ack & ~err & ~tmo_hit;
  assign expire   = wait_cyc & (cnt == LAST);

  // Counter, single-cycle timeout pulse and sticky timeout flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt      <= '0;
      tmo_hit  <= 1'b0;
      tmo_seen <= 1'b0;
    end else begin
      cnt      <= (wait_cyc && !expire) ? cnt + 16'd1 : '0;
      tmo_hit  <= expire;
      tmo_seen <= tmo_seen | tmo_hit;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit Wishbone slave bus among N_MST
// masters. The owner keeps the bus while its CYC stays high; a release
// always costs exactly one idle cycle before the next grant.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int N_MST   = 2,
  parameter int ADR_W   = ADR_W_DEF,
  parameter int TMO_CYC = 255
) (
  input logic            CLK,
  input logic            RST,
  wb_rr_arbiter_if.slave bus
);

  arb_state_t       state, state_nx;
  logic [N_MST-1:0] gnt, gnt_nx;
  logic [N_MST-1:0] pick;
  logic             found;
  logic [2:0]       ptr, ptr_nx;
  logic [2:0]       owner;
  logic             own;
  logic             own_stb;
  logic             tmo_hit;
  logic             tmo_seen;

  assign own   = (state == ST_OWN);
  assign owner = onehot_to_idx(8'(gnt));

  // Cyclic search for the first requester at or after the pointer.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_MST; i++) begin
      if (!found && bus.M_CYC[i] && (3'(i) >= ptr)) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int i = 0; i < N_MST; i++) begin
      if (!found && bus.M_CYC[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  // State, registered grant and round-robin pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      ptr   <= ptr_nx;
    end
  end

  // Grant on any request in IDLE; release when the owner drops CYC.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    ptr_nx   = ptr;
    case (state)
      ST_IDLE: begin
        if (|bus.M_CYC) begin
          state_nx = ST_OWN;
          gnt_nx   = pick;
        end
      end
      ST_OWN: begin
        if (!(|(bus.M_CYC & gnt))) begin
          state_nx = ST_IDLE;
          gnt_nx   = '0;
          ptr_nx   = (owner == 3'(N_MST - 1)) ? 3'd0 : owner + 3'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Route the owner onto the slave bus and the slave answer back to it only.
  always_comb begin
    own_stb    = 1'b0;
    bus.S_CYC  = 1'b0;
    bus.S_WE   = 1'b0;
    bus.S_ADR  = '0;
    bus.S_WDAT = '0;
    bus.M_ACK  = '0;
    bus.M_ERR  = '0;
    if (own) begin
      for (int i = 0; i < N_MST; i++) begin
        if (gnt[i]) begin
          bus.S_CYC    = bus.M_CYC[i];
          own_stb      = bus.M_STB[i];
          bus.S_WE     = bus.M_WE[i];
          bus.S_ADR    = bus.M_ADR[i*ADR_W +: ADR_W];
          bus.S_WDAT   = bus.M_WDAT[i*DATA_W +: DATA_W];
          bus.M_ACK[i] = bus.S_ACK;
          bus.M_ERR[i] = bus.S_ERR | tmo_hit;
        end
      end
    end
    bus.S_STB  = own_stb & ~tmo_hit;
    bus.M_RDAT = own ? bus.S_RDAT : '0;
  end

  assign bus.GNT      = gnt;
  assign bus.TMO_SEEN = tmo_seen;

  wb_tmo_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .CLK      (CLK),
    .RST      (RST),
    .own      (own),
    .stb      (own_stb),
    .ack      (bus.S_ACK),
    .err      (bus.S_ERR),
    .tmo_hit  (tmo_hit),
    .tmo_seen (tmo_seen)
  );

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: two masters, TMO_CYC = 8. A transaction-level
// model (current owner, next-in-line pointer, unanswered-wait count) predicts
// every output each cycle; directed literal checks pin key cycles.
module tb_wb_rr_arbiter;

  localparam int N   = 2;
  localparam int AW  = 16;
  localparam int TMO = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  wb_rr_arbiter_if #(.N_MST(N), .ADR_W(AW)) bus ();

  wb_rr_arbiter #(.N_MST(N), .ADR_W(AW), .TMO_CYC(TMO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bitof(input logic [7:0] v, input int i);
    logic [2:0] k;
    k = i[2:0];
    return v[k];
  endfunction

  // ---------------- behavioural model ----------------
  int m_owner = -1;   // -1 = bus free
  int m_ptr   = 0;    // first master to consider on the next grant
  int m_wait  = 0;    // consecutive unanswered strobe cycles of the owner
  bit m_err   = 0;    // this cycle is a timeout-error cycle
  bit m_seen  = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_owner = -1; m_ptr = 0; m_wait = 0; m_err = 0; m_seen = 0;
    end else if (m_owner < 0) begin
      if (m_err) m_seen = 1;
      m_err  = 0;
      m_wait = 0;
      for (int k = 0; k < N; k++)
        if (m_owner < 0 && bitof(8'(bus.M_CYC), (m_ptr + k) % N)) m_owner = (m_ptr + k) % N;
    end else begin
      if (m_err) m_seen = 1;
      if (bitof(8'(bus.M_STB), m_owner) && !bus.S_ACK && !bus.S_ERR && !m_err) begin
        m_wait++;
        if (m_wait == TMO) begin m_err = 1; m_wait = 0; end
        else m_err = 0;
      end else begin
        m_wait = 0;
        m_err  = 0;
      end
      if (!bitof(8'(bus.M_CYC), m_owner)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge CLK) begin
    logic [31:0] e_gnt, e_cyc, e_stb, e_we, e_adr, e_wd, e_ack, e_err, e_rd;
    e_gnt = 0; e_cyc = 0; e_stb = 0; e_we = 0; e_adr = 0;
    e_wd = 0; e_ack = 0; e_err = 0; e_rd = 0;
    if (!RST && m_owner >= 0) begin
      e_gnt = 32'(1) << m_owner;
      e_cyc = 32'(bitof(8'(bus.M_CYC), m_owner));
      e_stb = 32'(bitof(8'(bus.M_STB), m_owner) && !m_err);
      e_we  = 32'(bitof(8'(bus.M_WE), m_owner));
      e_adr = 32'((bus.M_ADR >> (m_owner * AW)) & 32'hFFFF);
      e_wd  = 32'((bus.M_WDAT >> (m_owner * 8)) & 16'hFF);
      e_ack = bus.S_ACK ? (32'(1) << m_owner) : 0;
      e_err = (bus.S_ERR || m_err) ? (32'(1) << m_owner) : 0;
      e_rd  = 32'(bus.S_RDAT);
    end
    check("mdl_gnt",  32'(bus.GNT),    e_gnt);
    check("mdl_scyc", 32'(bus.S_CYC),  e_cyc);
    check("mdl_sstb", 32'(bus.S_STB),  e_stb);
    check("mdl_swe",  32'(bus.S_WE),   e_we);
    check("mdl_sadr", 32'(bus.S_ADR),  e_adr);
    check("mdl_swd",  32'(bus.S_WDAT), e_wd);
    check("mdl_mack", 32'(bus.M_ACK),  e_ack);
    check("mdl_merr", 32'(bus.M_ERR),  e_err);
    check("mdl_mrd",  32'(bus.M_RDAT), e_rd);
    check("mdl_seen", 32'(bus.TMO_SEEN), 32'(!RST && m_seen));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.M_CYC = '0; bus.M_STB = '0; bus.M_WE = '0; bus.M_ADR = '0; bus.M_WDAT = '0;
    bus.S_RDAT = '0; bus.S_ACK = 1'b0; bus.S_ERR = 1'b0;

    neg();
    check("rst_gnt", 32'(bus.GNT), 0);
    check("rst_scyc", 32'(bus.S_CYC), 0);
    check("rst_mack", 32'(bus.M_ACK), 0);
    tick(); RST = 1'b0;

    // single write, master 0, ACK on the third strobe cycle
    tick(); bus.M_CYC = 2'b01; bus.M_STB = 2'b01; bus.M_WE = 2'b01;
    bus.M_ADR = {16'h0000, 16'h0102}; bus.M_WDAT = {8'h00, 8'hA5};
    neg(); check("wr_gnt_latency", 32'(bus.GNT), 0);
    tick(); neg();
    check("wr_gnt", 32'(bus.GNT), 32'h1);
    check("wr_sadr", 32'(bus.S_ADR), 32'h0102);
    check("wr_swdat", 32'(bus.S_WDAT), 32'hA5);
    check("wr_ack_c1", 32'(bus.M_ACK), 0);
    tick(); neg(); check("wr_ack_c2", 32'(bus.M_ACK), 0);
    tick(); bus.S_ACK = 1'b1; neg(); check("wr_ack_c3", 32'(bus.M_ACK), 32'h1);
    tick(); bus.S_ACK = 1'b0; bus.M_CYC = '0; bus.M_STB = '0; bus.M_WE = '0;
    neg(); check("wr_ack_c4", 32'(bus.M_ACK), 0); check("wr_gnt_hold", 32'(bus.GNT), 32'h1);
    tick(); neg(); check("wr_gnt_release", 32'(bus.GNT), 0);

    // collisions from a fresh reset
    tick(); RST = 1'b1; neg();
    tick(); RST = 1'b0;
    tick(); bus.M_CYC = 2'b11; neg(); check("coll_idle", 32'(bus.GNT), 0);
    tick(); bus.M_CYC = 2'b00; neg(); check("coll_m0_first", 32'(bus.GNT), 32'h1);
    tick(); bus.M_CYC = 2'b11; neg(); check("coll_released", 32'(bus.GNT), 0);
    tick(); bus.M_CYC = 2'b01; neg(); check("coll_m1_first", 32'(bus.GNT), 32'h2);
    tick(); neg(); check("coll_dead_cycle", 32'(bus.GNT), 0);
    tick(); bus.M_CYC = 2'b00; neg(); check("coll_m0_next", 32'(bus.GNT), 32'h1);

    // master 1 reads while master 0 strobes without CYC
    tick(); bus.M_CYC = 2'b10; bus.M_STB = 2'b11; bus.M_WE = 2'b01;
    bus.M_ADR = {16'h0200, 16'h0055}; bus.M_WDAT = {8'h00, 8'h11};
    neg(); check("rd_idle", 32'(bus.GNT), 0);
    tick(); neg();
    check("rd_gnt", 32'(bus.GNT), 32'h2);
    check("rd_sadr", 32'(bus.S_ADR), 32'h0200);
    check("rd_swe", 32'(bus.S_WE), 0);
    tick(); bus.S_ACK = 1'b1; bus.S_RDAT = 8'h3C; neg();
    check("rd_ack", 32'(bus.M_ACK), 32'h2);
    check("rd_rdat", 32'(bus.M_RDAT), 32'h3C);
    tick(); bus.S_ACK = 1'b0; bus.S_RDAT = 8'h00; bus.M_CYC = 2'b00; bus.M_STB = 2'b01;
    neg(); check("rd_ack_end", 32'(bus.M_ACK), 0);
    tick(); bus.S_ACK = 1'b1; bus.S_RDAT = 8'h77; neg();
    check("late_ack_drop", 32'(bus.M_ACK), 0);
    check("late_rdat_drop", 32'(bus.M_RDAT), 0);
    tick(); bus.S_ACK = 1'b0; bus.S_RDAT = 8'h00; bus.M_STB = 2'b00; bus.M_WE = 2'b00;
    neg(); check("stb_no_cyc_ignored", 32'(bus.GNT), 0);

    // watchdog: slave never answers master 0
    tick(); bus.M_CYC = 2'b01; bus.M_STB = 2'b01; bus.M_ADR = {16'h0000, 16'h0300}; neg();
    for (int i = 1; i <= 18; i++) begin
      tick(); neg();
      check("tmo_merr", 32'(bus.M_ERR), (i == 9 || i == 18) ? 32'h1 : 32'h0);
      check("tmo_sstb", 32'(bus.S_STB), (i == 9 || i == 18) ? 32'h0 : 32'h1);
      if (i == 10) check("tmo_seen", 32'(bus.TMO_SEEN), 32'h1);
    end
    tick(); bus.M_CYC = '0; bus.M_STB = '0; neg();
    tick(); neg();

    // ACK on the 8th wait cycle beats the timeout (master 1)
    tick(); bus.M_CYC = 2'b10; bus.M_STB = 2'b10; bus.M_WE = 2'b10;
    bus.M_ADR = {16'h0400, 16'h0000}; neg();
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 8) bus.S_ACK = 1'b1;
      neg();
      if (i == 8) begin
        check("race_ack", 32'(bus.M_ACK), 32'h2);
        check("race_noerr", 32'(bus.M_ERR), 0);
      end
    end
    tick(); bus.S_ACK = 1'b0; bus.M_CYC = '0; bus.M_STB = '0; bus.M_WE = '0;
    neg(); check("race_no_late_err", 32'(bus.M_ERR), 0);
    tick(); neg();

    // reset during master 1's transfer, then pointer starts over at 0
    tick(); bus.M_CYC = 2'b01; neg();
    tick(); bus.M_CYC = 2'b00; neg(); check("pre_m0", 32'(bus.GNT), 32'h1);
    tick(); bus.M_CYC = 2'b11; bus.M_STB = 2'b11; neg();
    tick(); neg(); check("pre_rst_m1", 32'(bus.GNT), 32'h2);
    tick(); #2; RST = 1'b1; bus.S_ACK = 1'b1; #1;
    check("arst_gnt", 32'(bus.GNT), 0);
    check("arst_scyc", 32'(bus.S_CYC), 0);
    check("arst_sstb", 32'(bus.S_STB), 0);
    check("arst_sadr", 32'(bus.S_ADR), 0);
    check("arst_mack", 32'(bus.M_ACK), 0);
    check("arst_merr", 32'(bus.M_ERR), 0);
    neg();
    tick(); bus.S_ACK = 1'b0; neg();
    tick(); RST = 1'b0; neg(); check("post_rst_idle", 32'(bus.GNT), 0);
    tick(); neg(); check("ptr_reset_m0", 32'(bus.GNT), 32'h1);
    tick(); bus.M_CYC = '0; bus.M_STB = '0; neg();
    tick(); neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
